keypad_matrix_scanner: RTL

//  Scans a 4x4 active-low key matrix: drives one column low at a time and samples the rows.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_matrix_scanner_if.sv | 27 ++
 rtl/keypad_scan_div.sv | 28 ++
 rtl/keypad_matrix_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad matrix scanner.
// Key codes are {row_idx[1:0], col_idx[1:0]}.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    // Vending keypad legend, row-major from the top-left key
    localparam logic [3:0] KEY_SEL_A     = 4'h0;
    localparam logic [3:0] KEY_SEL_B     = 4'h1;
    localparam logic [3:0] KEY_SEL_C     = 4'h2;
    localparam logic [3:0] KEY_SEL_D     = 4'h3;
    localparam logic [3:0] KEY_COIN_MENU = 4'hD;
    localparam logic [3:0] KEY_CANCEL    = 4'hE;
    localparam logic [3:0] KEY_CONFIRM   = 4'hF;

    localparam logic [3:0] COL_DRIVE [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else if (!rows[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Keypad matrix and key-event bundle between the scanner (master) and its
// consumer / matrix model (slave).
interface keypad_matrix_scanner_if;

    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (
        input  row_in,
        output col_out,
        output key_valid,
        output key_code,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_valid,
        input  key_code,
        input  key_held
    );

endinterface

// File: rtl/keypad_scan_div.sv
// Column dwell divider: counts 0..SCAN_DIV-1 and flags the last cycle of
// each dwell as the scan tick.
module keypad_scan_div #(
    parameter int SCAN_DIV = 25000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

    logic [W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner with tick-based debounce of press and release.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
//
// state    | meaning
// SCAN     | walking the columns, waiting for any low row
// DEBOUNCE | column frozen, counting ticks the latched row stays the lowest low
// HELD     | key accepted, waiting for the latched row to go high
// RELEASE  | counting ticks the latched row stays high
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 200,
    parameter int REPEAT_RATE    = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    keypad_matrix_scanner_if.master kp
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 1 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_matrix_scanner: all timing parameters must be at least 1");
    end

    scan_state_t   state, state_next;
    logic [1:0]    col_idx, col_next;
    logic [1:0]    row_idx, row_next;
    logic [CW-1:0] count, count_next, count_inc;
    logic [3:0]    code_reg, code_next;
    logic          valid_pulse, valid_next;
    logic          held_flag, held_next;
    logic [3:0]    row_meta, row_sync;
    logic          tick;
    logic          any_low, latched_low;
    logic [1:0]    low_row;
    logic          accept, release_done;

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE);

    logic [RW-1:0] rep_cnt, rep_cnt_next, rep_inc;
    logic          rep_armed, rep_armed_next;

    assign rep_inc = rep_cnt + RW'(1);
`endif

    keypad_scan_div #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Rows idle high through the pull-ups, so the synchronizer resets to "no key"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= kp.row_in;
            row_sync <= row_meta;
        end
    end

    assign any_low     = (row_sync != 4'hF);
    assign low_row     = lowest_low_row(row_sync);
    assign latched_low = !row_sync[row_idx];
    assign count_inc   = count + CW'(1);

    always_comb begin
        state_next   = state;
        col_next     = col_idx;
        row_next     = row_idx;
        count_next   = count;
        code_next    = code_reg;
        valid_next   = 1'b0;
        held_next    = held_flag;
        accept       = 1'b0;
        release_done = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_next   = rep_cnt;
        rep_armed_next = rep_armed;
`endif
        if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        row_next   = low_row;
                        count_next = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_next = DEBOUNCE;
                        end
                    end else begin
                        col_next = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (latched_low && (low_row == row_idx)) begin
                        count_next = count_inc;
                        if (count_inc == DEB_LAST) begin
                            accept = 1'b1;
                        end
                    end else begin
                        state_next = SCAN;
                    end
                end
                HELD: begin
                    if (!latched_low) begin
                        count_next = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            release_done = 1'b1;
                        end else begin
                            state_next = RELEASE;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_inc == (rep_armed ? RATE_LAST : DELAY_LAST)) begin
                        valid_next     = 1'b1;
                        rep_cnt_next   = '0;
                        rep_armed_next = 1'b1;
                    end else begin
                        rep_cnt_next = rep_inc;
                    end
`endif
                end
                RELEASE: begin
                    if (latched_low) begin
                        state_next = HELD;
                    end else if (count_inc == DEB_LAST) begin
                        release_done = 1'b1;
                    end else begin
                        count_next = count_inc;
                    end
                end
                default: state_next = SCAN;
            endcase
        end

        if (accept) begin
            state_next = HELD;
            code_next  = {row_next, col_idx};
            valid_next = 1'b1;
            held_next  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_next   = '0;
            rep_armed_next = 1'b0;
`endif
        end

        // Resume scanning at the next column so a stuck key cannot monopolise the scan
        if (release_done) begin
            state_next = SCAN;
            held_next  = 1'b0;
            col_next   = col_idx + 2'd1;
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN;
            col_idx     <= 2'd0;
            row_idx     <= 2'd0;
            count       <= '0;
            code_reg    <= 4'h0;
            valid_pulse <= 1'b0;
            held_flag   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
            rep_armed   <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            col_idx     <= col_next;
            row_idx     <= row_next;
            count       <= count_next;
            code_reg    <= code_next;
            valid_pulse <= valid_next;
            held_flag   <= held_next;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= rep_cnt_next;
            rep_armed   <= rep_armed_next;
`endif
        end
    end

    assign kp.col_out   = COL_DRIVE[col_idx];
    assign kp.key_valid = valid_pulse;
    assign kp.key_code  = code_reg;
    assign kp.key_held  = held_flag;

endmodule
